// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: FSM encoding, register map,
// default number of interrupt sources.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 8;

  // State encoding is visible in STATUS[5:4], so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_MASK     = 2'd0;
  localparam logic [1:0] ADDR_PENDING  = 2'd1;
  localparam logic [1:0] ADDR_OVERFLOW = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

endpackage

// File: rtl/irq_controller_if.sv
// Interrupt request handshake between the controller and the core.
//
// Handshake: the controller raises irq with a stable irq_id and holds both
// until it sees irq_ack (one-cycle pulse) or withdraws the request because
// the source was masked or its pending bit was cleared. After irq_ack the
// core runs the handler and signals completion with a one-cycle irq_eoi; no
// new request is raised between irq_ack and irq_eoi.
interface irq_controller_if #(
  parameter int ID_W = 3
);
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic            irq_ack;
  logic            irq_eoi;

  modport master (output irq, output irq_id, input irq_ack, input irq_eoi);
  modport slave  (input irq, input irq_id, output irq_ack, output irq_eoi);
endinterface

// File: rtl/irq_sync_edge.sv
// One interrupt line: two-flop synchronizer followed by rising-edge detect.
module irq_sync_edge (
  input  logic ph1,
  input  logic reset,
  input  logic din,
  output logic rise_o
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Shift the raw line through the synchronizer and the history flop.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = s2_q & ~prev_q;
endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches rising edges as pending, masks them, picks the
// lowest enabled index and presents it to the core with req/ack/eoi.
module irq_controller
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ    = NUM_IRQ_DEF,
  parameter int         ID_W       = 3,
  parameter logic [7:0] MASK_RESET = 8'hFF
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] interrupts,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [7:0]         cfg_wdata,
  output logic [7:0]         cfg_rdata,
  irq_controller_if.master   core,
  output irq_state_e         dbg_state
);
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] overflow_q, overflow_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] req_vec, ack_clr;
  irq_state_e         state_q, state_d;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [ID_W-1:0]    in_service_q, in_service_d;
  logic [ID_W-1:0]    winner;
  logic [7:0]         cfg_rdata_q, cfg_rdata_d;
  logic               ack_take;
  logic               wr_mask, wr_pend, wr_ovf;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge u_sync (.ph1(ph1), .reset(reset), .din(interrupts[i]), .rise_o(rise[i]));
  end

  assign wr_mask = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_pend = cfg_we && (cfg_addr == ADDR_PENDING);
  assign wr_ovf  = cfg_we && (cfg_addr == ADDR_OVERFLOW);
  assign req_vec = pending_q & mask_q;

  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_vec[i]) winner = ID_W'(i);
    end
  end

  // Request FSM: arbitrate in IDLE, hold the id in REQ, wait for eoi in SERVICE.
  always_comb begin
    state_d      = state_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    in_service_d = in_service_q;
    ack_take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d  = ST_REQ;
          irq_id_d = winner;
          irq_d    = 1'b1;
        end
      end
      ST_REQ: begin
        if (core.irq_ack) begin
          ack_take     = 1'b1;
          in_service_d = irq_id_q;
          irq_d        = 1'b0;
          state_d      = ST_SERVICE;
        end else if ((wr_mask && !cfg_wdata[irq_id_q]) ||
                     (wr_pend && cfg_wdata[irq_id_q])) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (core.irq_eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // Pending/overflow/mask updates; a new edge always wins over a clear.
  always_comb begin
    ack_clr    = ack_take ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id_q) : '0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    mask_d     = mask_q;
    if (wr_pend) pending_d = pending_d & ~cfg_wdata[NUM_IRQ-1:0];
    if (wr_ovf)  overflow_d = overflow_d & ~cfg_wdata[NUM_IRQ-1:0];
    if (wr_mask) mask_d = cfg_wdata[NUM_IRQ-1:0];
    pending_d  = (pending_d & ~ack_clr) | rise;
    overflow_d = overflow_d | (rise & pending_q);
  end

  // Registered read mux, updated every cycle.
  always_comb begin
    cfg_rdata_d = '0;
    case (cfg_addr)
      ADDR_MASK:     cfg_rdata_d[NUM_IRQ-1:0] = mask_q;
      ADDR_PENDING:  cfg_rdata_d[NUM_IRQ-1:0] = pending_q;
      ADDR_OVERFLOW: cfg_rdata_d[NUM_IRQ-1:0] = overflow_q;
      default:       cfg_rdata_d = {2'b00, state_q, 3'(in_service_q), irq_q};
    endcase
  end

  // All controller state.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      in_service_q <= '0;
      pending_q    <= '0;
      overflow_q   <= '0;
      mask_q       <= MASK_RESET[NUM_IRQ-1:0];
      cfg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      mask_q       <= mask_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  assign core.irq    = irq_q;
  assign core.irq_id = irq_id_q;
  assign cfg_rdata   = cfg_rdata_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus a short random loop.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int NUM = 8;

  logic           ph1;
  logic           reset;
  logic [NUM-1:0] interrupts;
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [7:0]     cfg_wdata;
  logic [7:0]     cfg_rdata;
  irq_state_e     dbg_state;

  irq_controller_if #(.ID_W(3)) core_if ();

  irq_controller #(.NUM_IRQ(NUM), .ID_W(3), .MASK_RESET(8'hFF)) dut (
    .ph1(ph1), .reset(reset), .interrupts(interrupts),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .core(core_if), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge ph1);
  endtask

  task automatic pulse(input logic [NUM-1:0] lines, input int cycles);
    interrupts = lines;
    repeat (cycles) tick();
    interrupts = '0;
  endtask

  task automatic ack();
    core_if.irq_ack = 1'b1;
    tick();
    core_if.irq_ack = 1'b0;
  endtask

  task automatic eoi();
    core_if.irq_eoi = 1'b1;
    tick();
    core_if.irq_eoi = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Scoreboard: push the expectation, let the DUT respond, pop and compare.
  task automatic cfg_read(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    cfg_addr = addr;
    tick();
    e = exp_q.pop_front();
    check(tag, cfg_rdata, e);
  endtask

  task automatic wait_irq(input string tag, input logic [7:0] exp_id);
    logic [7:0] e;
    int n;
    n = 0;
    exp_q.push_back(exp_id);
    while (core_if.irq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    if (core_if.irq !== 1'b1) check({tag, "_irq_timeout"}, core_if.irq, 1);
    else check(tag, 8'(core_if.irq_id), e);
  endtask

  initial begin
    reset = 1'b0;
    interrupts = '0;
    cfg_we = 1'b0; cfg_addr = ADDR_MASK; cfg_wdata = '0;
    core_if.irq_ack = 1'b0; core_if.irq_eoi = 1'b0;
    repeat (3) tick();
    check("rst_irq", core_if.irq, 0);
    check("rst_irq_id", core_if.irq_id, 0);
    check("rst_rdata", cfg_rdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    cfg_read("rst_mask", ADDR_MASK, 8'hFF);
    cfg_read("rst_status", ADDR_STATUS, 8'h00);

    // Single line: exact latency, then ack and eoi.
    interrupts = 8'h02;
    repeat (3) tick();
    check("lat_e3_irq", core_if.irq, 0);
    tick();
    check("lat_e4_irq", core_if.irq, 1);
    check("lat_e4_id", core_if.irq_id, 1);
    tick();
    interrupts = '0;
    cfg_read("t1_pending", ADDR_PENDING, 8'h02);
    ack();
    check("t1_ack_irq", core_if.irq, 0);
    cfg_read("t1_status_svc", ADDR_STATUS, 8'h22);
    eoi();
    cfg_read("t1_status_idle", ADDR_STATUS, 8'h02);
    cfg_read("t1_pending_clr", ADDR_PENDING, 8'h00);

    // Two lines together: lowest index first, second one two edges after eoi.
    pulse(8'h03, 2);
    wait_irq("t2_first", 0);
    ack();
    eoi();
    check("t2_eoi_plus1", core_if.irq, 0);
    tick();
    check("t2_eoi_plus2", core_if.irq, 1);
    check("t2_second_id", core_if.irq_id, 1);
    ack();
    eoi();
    tick();

    // Same line during its own service: latched, overflow on the second pulse.
    pulse(8'h02, 2);
    wait_irq("t3_first", 1);
    ack();
    pulse(8'h02, 2);
    repeat (4) tick();
    check("t3_svc_irq", core_if.irq, 0);
    cfg_read("t3_pending", ADDR_PENDING, 8'h02);
    pulse(8'h02, 2);
    repeat (4) tick();
    check("t3_svc_irq2", core_if.irq, 0);
    cfg_read("t3_overflow", ADDR_OVERFLOW, 8'h02);
    cfg_write(ADDR_OVERFLOW, 8'h02);
    cfg_read("t3_overflow_clr", ADDR_OVERFLOW, 8'h00);
    eoi();
    wait_irq("t3_replay", 1);
    ack();
    eoi();
    cfg_read("t3_pending_clr", ADDR_PENDING, 8'h00);

    // Masked line stays pending, fires when enabled.
    cfg_write(ADDR_MASK, 8'h00);
    pulse(8'h08, 2);
    repeat (5) tick();
    check("t4_masked_irq", core_if.irq, 0);
    cfg_read("t4_pending", ADDR_PENDING, 8'h08);
    cfg_write(ADDR_MASK, 8'h08);
    wait_irq("t4_unmask", 3);
    ack();
    eoi();
    cfg_write(ADDR_MASK, 8'hFF);

    // Withdraw by masking while in REQ, then ack racing the same mask write.
    pulse(8'h04, 2);
    wait_irq("t5_req", 2);
    cfg_write(ADDR_MASK, 8'hFB);
    check("t5_withdraw_irq", core_if.irq, 0);
    cfg_read("t5_status", ADDR_STATUS, 8'h06);
    cfg_read("t5_pending", ADDR_PENDING, 8'h04);
    cfg_write(ADDR_MASK, 8'hFF);
    wait_irq("t5_rereq", 2);
    core_if.irq_ack = 1'b1;
    cfg_write(ADDR_MASK, 8'hFB);
    core_if.irq_ack = 1'b0;
    check("t5_ack_irq", core_if.irq, 0);
    cfg_read("t5_status_svc", ADDR_STATUS, 8'h24);
    eoi();
    cfg_write(ADDR_MASK, 8'hFF);

    // Random single-line round trips.
    for (int k = 0; k < 6; k++) begin
      int line;
      int width;
      line  = $urandom_range(0, NUM - 1);
      width = $urandom_range(1, 4);
      pulse(8'(1 << line), width);
      wait_irq("rnd_id", 8'(line));
      ack();
      eoi();
      cfg_read("rnd_pending", ADDR_PENDING, 8'h00);
    end

    // Asynchronous reset in the middle of a service.
    pulse(8'h05, 2);
    wait_irq("t6_req", 0);
    ack();
    pulse(8'h01, 2);
    repeat (4) tick();
    cfg_write(ADDR_MASK, 8'h12);
    cfg_read("t6_pending", ADDR_PENDING, 8'h05);
    check("t6_pre_state", dbg_state, ST_SERVICE);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_irq", core_if.irq, 0);
    check("t6_rst_rdata", cfg_rdata, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    tick();
    reset = 1'b1;
    cfg_read("t6_mask", ADDR_MASK, 8'hFF);
    cfg_read("t6_pending_rst", ADDR_PENDING, 8'h00);
    cfg_read("t6_status", ADDR_STATUS, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
